// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, length-field width, byte order.
package prog_loader_pkg;

    localparam int CNT_W = 16;

    // First byte of each frame word lands in bits 7:0.
    localparam bit BYTE_LSB_FIRST = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_START  = 3'd5;
    localparam logic [2:0] ST_RUN    = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LEN_LO = ST_LEN_LO,
        S_LEN_HI = ST_LEN_HI,
        S_DATA   = ST_DATA,
        S_CSUM   = ST_CSUM,
        S_START  = ST_START,
        S_RUN    = ST_RUN,
        S_ERROR  = ST_ERROR
    } state_t;

    function automatic logic rx_state(input state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four accepted bytes into one instruction word and pulses word_ready with it.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic [1:0]       byte_cnt,
    output logic             word_ready,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] placed;
    logic [1:0]       lane;

    assign lane = BYTE_LSB_FIRST ? byte_cnt : 2'd3 - byte_cnt;

    always_comb begin
        placed = asm_q;
        placed[{lane, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= 2'd0;
            asm_q      <= '0;
            word_ready <= 1'b0;
            word       <= '0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                // A restart throws away whatever partial word was collected.
                byte_cnt <= 2'd0;
                asm_q    <= '0;
            end else if (in_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word       <= placed;
                    word_ready <= 1'b1;
                    asm_q      <= '0;
                end else begin
                    asm_q <= placed;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, little-endian words into instruction memory,
// then releases the core with a go_contr pulse. PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  core_hold,
    output logic                  go_contr,
    output logic                  busy,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CNT_W:0]        CAP  = (CNT_W+1)'(1) << (ADDR_WIDTH - 2);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER = S_CSUM;
`else
    localparam state_t S_AFTER = S_START;
`endif

    state_t           state, nxt;
    logic [7:0]       n_lo;
    logic [CNT_W-1:0] n_len;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] len_in;
    logic [1:0]       byte_cnt;
    logic             take;
    logic             last_word;
    logic             last_byte;

    // A restart wins over a byte offered in the same cycle; that byte is dropped.
    assign take      = rx_valid & rx_ready & ~load_start;
    assign len_in    = {rx_data, n_lo};
    assign last_word = (word_cnt == n_len - CNT_W'(1));
    assign last_byte = (state == S_DATA) & take & (byte_cnt == 2'd3) & last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            csum <= 8'd0;
        else if (load_start)
            csum <= 8'd0;
        else if (take && state == S_DATA)
            csum <= csum ^ rx_data;
    end
`endif

    prog_loader_byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start),
        .in_valid   (take && state == S_DATA),
        .in_data    (rx_data),
        .byte_cnt   (byte_cnt),
        .word_ready (mem_we),
        .word       (mem_wdata)
    );

    always_comb begin
        nxt = state;
        if (load_start) begin
            nxt = S_LEN_LO;
        end else begin
            case (state)
                S_LEN_LO: if (take) nxt = S_LEN_HI;
                S_LEN_HI: begin
                    if (take) begin
                        if (len_in == '0)
                            nxt = S_AFTER;
                        else if ({1'b0, len_in} > CAP)
                            nxt = S_ERROR;
                        else
                            nxt = S_DATA;
                    end
                end
                // Leave DATA on the write cycle of the final word.
                S_DATA: if (mem_we && last_word) nxt = S_AFTER;
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: if (take) nxt = (rx_data == csum) ? S_START : S_ERROR;
`endif
                S_START: nxt = S_RUN;
                default: nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b0;
            core_hold <= 1'b1;
            go_contr  <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            mem_addr  <= BASE;
            word_cnt  <= '0;
            n_lo      <= 8'd0;
            n_len     <= '0;
        end else begin
            state     <= nxt;
            // After the final data byte, hold off further bytes until the FSM moves on.
            rx_ready  <= rx_state(nxt) && !last_byte;
            core_hold <= !(nxt == S_START || nxt == S_RUN);
            go_contr  <= (nxt == S_START);
            busy      <= !(nxt == S_IDLE || nxt == S_RUN || nxt == S_ERROR);
            error     <= (nxt == S_ERROR);

            if (load_start) begin
                mem_addr <= BASE;
                word_cnt <= '0;
            end else if (mem_we) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(4);
                word_cnt <= word_cnt + CNT_W'(1);
            end

            if (take && state == S_LEN_LO)
                n_lo <= rx_data;
            if (take && state == S_LEN_HI)
                n_len <= len_in;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model against observed memory writes.
module tb_prog_loader;

    localparam int AW  = 12;
    localparam int CAP = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          go_contr;
    logic          busy;
    logic          error;

    always #5 clk = ~clk;

    prog_loader #(.WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .go_contr   (go_contr),
        .busy       (busy),
        .error      (error)
    );

    int errors = 0;
    int checks = 0;
    int go_cnt = 0;
    int go_hold_bad = 0;
    int go_base = 0;

    logic [AW+31:0] obs_q[$];
    logic [AW+31:0] exp_q[$];
    logic [7:0]     frame_q[$];
    int             exp_go;
    int             exp_err;
    int             nsend;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
            if (go_contr === 1'b1) begin
                go_cnt++;
                if (core_hold !== 1'b0) go_hold_bad++;
            end
        end
    end

    // Reference: parse the frame as a whole and derive writes, start and error outcome.
    task automatic compute_expected();
        int n;
        logic [7:0] x;
        bit csum_ok;
        n = int'(frame_q[0]) | (int'(frame_q[1]) << 8);
        exp_q.delete();
        x = 8'd0;
        if (n > CAP) begin
            exp_go = 0; exp_err = 1; nsend = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = {frame_q[2+4*i+3], frame_q[2+4*i+2], frame_q[2+4*i+1], frame_q[2+4*i]};
            exp_q.push_back({AW'(4 * i), w});
        end
        for (int i = 0; i < 4 * n; i++) x = x ^ frame_q[2+i];
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_ok = (frame_q[2+4*n] == x);
`else
        csum_ok = (x == x);
`endif
        exp_go  = csum_ok ? 1 : 0;
        exp_err = csum_ok ? 0 : 1;
        nsend   = frame_q.size();
    endtask

    task automatic finish_frame();
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        for (int i = 2; i < frame_q.size(); i++) x = x ^ frame_q[i];
        frame_q.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        n = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout rx_ready=%b want 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input int max_gap, input bit do_start);
        int n;
        compute_expected();
        go_base = go_cnt;
        if (do_start) pulse_start();
        for (int i = 0; i < nsend; i++) send_byte(frame_q[i], max_gap);
        n = 0;
        while (go_cnt == go_base && error !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL frame_end_timeout go=%0d error=%b", go_cnt - go_base, error);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (2) @(negedge clk);
        checks++; if (rx_ready !== 1'b0)   begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== '0)     begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== '0)    begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        checks++; if (core_hold !== 1'b1)  begin errors++; $display("FAIL reset_core_hold got %b want 1", core_hold); end
        checks++; if (go_contr !== 1'b0)   begin errors++; $display("FAIL reset_go got %b want 0", go_contr); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_busy_error got %b%b want 00", busy, error);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rx_ready !== 1'b0 || core_hold !== 1'b1) begin
            errors++; $display("FAIL idle_outputs rx_ready=%b core_hold=%b want 0/1", rx_ready, core_hold);
        end
    endtask

    task automatic test_basic();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        finish_frame();
        obs_q.delete();
        run_frame(0, 1'b1);
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL basic_nwrites got %0d want 2", obs_q.size()); end
        checks++; if (obs_q.size() > 0 && obs_q[0] !== {12'h000, 32'h00000013}) begin
            errors++; $display("FAIL basic_write0 got %h want 00000000013", obs_q[0]);
        end
        checks++; if (obs_q.size() > 1 && obs_q[1] !== {12'h004, 32'h00100093}) begin
            errors++; $display("FAIL basic_write1 got %h want 00400100093", obs_q[1]);
        end
        checks++; if (go_cnt - go_base !== 1) begin errors++; $display("FAIL basic_go got %0d want 1", go_cnt - go_base); end
        checks++; if (go_hold_bad !== 0) begin errors++; $display("FAIL basic_hold_at_go got %0d want 0", go_hold_bad); end
        checks++; if (core_hold !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL basic_run hold=%b busy=%b err=%b want 000", core_hold, busy, error);
        end
    endtask

    task automatic test_zero_len();
        frame_q = '{8'h00, 8'h00};
        finish_frame();
        obs_q.delete();
        run_frame(0, 1'b1);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", obs_q.size()); end
        checks++; if (go_cnt - go_base !== 1) begin errors++; $display("FAIL zero_go got %0d want 1", go_cnt - go_base); end
    endtask

    task automatic test_overflow();
        frame_q = '{8'h01, 8'h04};
        obs_q.delete();
        run_frame(0, 1'b1);
        checks++; if (error !== 1'b1 || core_hold !== 1'b1) begin
            errors++; $display("FAIL ovf_error err=%b hold=%b want 1/1", error, core_hold);
        end
        checks++; if (go_cnt - go_base !== 0 || obs_q.size() !== 0) begin
            errors++; $display("FAIL ovf_no_go go=%0d writes=%0d want 0/0", go_cnt - go_base, obs_q.size());
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %b want 0", busy); end
        pulse_start();
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL ovf_restart err=%b busy=%b want 0/1", error, busy);
        end
    endtask

    task automatic test_restart();
        obs_q.delete();
        pulse_start();
        send_byte(8'h03, 2);
        send_byte(8'h00, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, 2);
        // Restart while another byte is offered: that byte must be dropped.
        while (rx_ready !== 1'b1) @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h55; load_start = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; load_start = 1'b0;
        frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        finish_frame();
        run_frame(3, 1'b0);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL restart_nwrites got %0d want 1", obs_q.size()); end
        checks++; if (obs_q.size() > 0 && obs_q[0] !== {12'h000, 32'hDDCCBBAA}) begin
            errors++; $display("FAIL restart_word got %h want 000DDCCBBAA", obs_q[0]);
        end
        checks++; if (go_cnt - go_base !== 1) begin errors++; $display("FAIL restart_go got %0d want 1", go_cnt - go_base); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            int n;
            n = $urandom_range(6, 1);
            frame_q.delete();
            frame_q.push_back(8'(n));
            frame_q.push_back(8'h00);
            for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
            finish_frame();
            obs_q.delete();
            run_frame((f == 0) ? 0 : $urandom_range(3, 0), 1'b1);
            checks++; if (obs_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_nwrites got %0d want %0d", f, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_write%0d got %h want %h", f, i, obs_q[i], exp_q[i]);
                end
            end
            checks++; if (go_cnt - go_base !== exp_go || error !== exp_err[0]) begin
                errors++; $display("FAIL rand%0d_end go=%0d err=%b want %0d/%0d", f, go_cnt - go_base, error, exp_go, exp_err);
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h31 + i), 0);
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL areset_mem addr=%h data=%h we=%b want 0/0/0", mem_addr, mem_wdata, mem_we);
        end
        checks++; if (rx_ready !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b1 || go_contr !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL areset_ctrl rdy=%b busy=%b hold=%b go=%b err=%b want 0 0 1 0 0",
                               rx_ready, busy, core_hold, go_contr, error);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_ready !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b1) begin
            errors++; $display("FAIL areset_idle rdy=%b busy=%b hold=%b want 0 0 1", rx_ready, busy, core_hold);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        frame_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        obs_q.delete();
        run_frame(0, 1'b1);
        checks++; if (go_cnt - go_base !== 1 || error !== 1'b0) begin
            errors++; $display("FAIL csum_good go=%0d err=%b want 1/0", go_cnt - go_base, error);
        end
        frame_q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        obs_q.delete();
        run_frame(0, 1'b1);
        checks++; if (go_cnt - go_base !== 0 || error !== 1'b1) begin
            errors++; $display("FAIL csum_bad go=%0d err=%b want 0/1", go_cnt - go_base, error);
        end
        checks++; if (obs_q.size() !== 1 || obs_q[0] !== {12'h000, 32'h08040201}) begin
            errors++; $display("FAIL csum_bad_write n=%0d want 1 word 08040201", obs_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_restart();
        test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
